// File: rtl/mips_pc_pkg.sv
// -----------------------------------------------------------------------------
// mips_pc_pkg
// Shared definitions for the MIPS program-counter sequencer:
//   - pc_src_e     : encoding of the pc_src_i control field
//   - seq_state_e  : sequencer FSM states
//   - INSTR_BYTES  : size of one instruction in bytes
//   - word_misaligned() : helper that flags a non word-aligned byte address
// -----------------------------------------------------------------------------
package mips_pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_JUMP   = 2'b01,
        PC_BRANCH = 2'b10,
        PC_JR     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } seq_state_e;

    localparam int INSTR_BYTES = 4;

    // True when the two low address bits are not both zero.
    function automatic logic word_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. A push when full overwrites the oldest entry;
// a pop when empty is ignored (the caller detects it through 'empty').
// Parameters: DEPTH (entries, >= 1), W (entry width)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data as the new top entry
//   pop         : discard the top entry
//   push_data   : value to push
//   top         : current top entry (valid when !empty)
//   empty, full : occupancy flags
// -----------------------------------------------------------------------------
module ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;      // next slot to write
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] top_idx_s;
    logic [PTR_W-1:0] next_ptr_s;

    // Index of the most recent entry and of the slot after the write pointer.
    always_comb begin
        top_idx_s  = '0;
        next_ptr_s = '0;
        if (wr_ptr_r == PTR_W'(0)) begin
            top_idx_s = PTR_W'(DEPTH - 1);
        end else begin
            top_idx_s = wr_ptr_r - PTR_W'(1);
        end
        if (wr_ptr_r == PTR_W'(DEPTH - 1)) begin
            next_ptr_s = PTR_W'(0);
        end else begin
            next_ptr_s = wr_ptr_r + PTR_W'(1);
        end
    end

    assign empty = (count_r == CNT_W'(0));
    assign full  = (count_r == CNT_W'(DEPTH));
    assign top   = mem_r[top_idx_s];

    // Storage, pointer and occupancy update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (push) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= next_ptr_s;
            if (!full) begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr_r <= top_idx_s;
            count_r  <= count_r - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for the MIPS core. Holds the architectural PC,
// handshakes fetch with instruction memory and applies sequential, branch,
// J/JAL and JR updates once per retired instruction. A JR to a non word-aligned
// target halts the core (sticky misalign_o) until reset.
// Optional feature macro: PC_SEQ_RAS_EN -- adds a RAS_DEPTH-entry return-address
// stack that checks JR-return targets and pulses ras_mismatch_o on a miss.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_o        fetch request for the instruction at pc_o
//   imem_ack_i        instruction returned (honoured only in FETCH)
//   valid_i, stall_i  decode handshake; stall wins over valid
//   pc_src_i          00 seq, 01 J/JAL, 10 branch taken, 11 JR
//   link_i, ret_i     JAL marker, JR-is-return marker
//   jaddr_i, boff_i   jump target field, signed branch word offset
//   rs_val_i          JR target
//   pc_o, pc_plus_o   current PC and PC+4
//   redirect_o        pulse: last accepted update was non-sequential
//   misalign_o        sticky: misaligned JR, core halted
//   ras_mismatch_o    pulse: return prediction missed (0 without RAS)
// -----------------------------------------------------------------------------
module pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    input  logic            imem_ack_i,
    input  logic            valid_i,
    input  logic            stall_i,
    input  logic [1:0]      pc_src_i,
    input  logic            link_i,
    input  logic            ret_i,
    input  logic [25:0]     jaddr_i,
    input  logic [15:0]     boff_i,
    input  logic [PC_W-1:0] rs_val_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus_o,
    output logic            redirect_o,
    output logic            misalign_o,
    output logic            ras_mismatch_o
);

    seq_state_e      state_r;
    logic [PC_W-1:0] pc_r;
    logic            req_r;
    logic            redirect_r;
    logic            misalign_r;

    pc_src_e         pc_src_s;
    logic [PC_W-1:0] pc_plus_s;
    logic [PC_W-1:0] next_pc_s;
    logic            accept_s;   // instruction retires this cycle (incl. halting JR)
    logic            jr_bad_s;   // accepted JR with misaligned target
    logic            update_s;   // accepted and PC actually moves

    assign pc_src_s  = pc_src_e'(pc_src_i);
    assign pc_plus_s = pc_r + PC_W'(INSTR_BYTES);
    assign accept_s  = (state_r == ST_EXEC) && valid_i && !stall_i;
    assign jr_bad_s  = accept_s && (pc_src_s == PC_JR) && word_misaligned(rs_val_i[1:0]);
    assign update_s  = accept_s && !jr_bad_s;

    // Next-PC selection; all arithmetic wraps modulo 2^PC_W.
    always_comb begin
        next_pc_s = pc_plus_s;
        case (pc_src_s)
            PC_SEQ: begin
                next_pc_s = pc_plus_s;
            end
            PC_BRANCH: begin
                next_pc_s = pc_plus_s + {{(PC_W-18){boff_i[15]}}, boff_i, 2'b00};
            end
            PC_JUMP: begin
                // Upper bits (if any above bit 27) come from pc+4.
                next_pc_s        = pc_plus_s;
                next_pc_s[27:0]  = {jaddr_i, 2'b00};
            end
            PC_JR: begin
                next_pc_s = rs_val_i;
            end
            default: begin
                next_pc_s = pc_plus_s;
            end
        endcase
    end

    // Sequencer FSM with registered PC, fetch request and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            req_r      <= 1'b0;
            redirect_r <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            redirect_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_FETCH;
                    req_r   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack_i) begin
                        state_r <= ST_EXEC;
                        req_r   <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (jr_bad_s) begin
                        state_r    <= ST_HALT;
                        misalign_r <= 1'b1;
                    end else if (update_s) begin
                        pc_r       <= next_pc_s;
                        redirect_r <= (pc_src_s != PC_SEQ);
                        state_r    <= ST_FETCH;
                        req_r      <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                    req_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_HALT;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o = req_r;
    assign pc_o       = pc_r;
    assign pc_plus_o  = pc_plus_s;
    assign redirect_o = redirect_r;
    assign misalign_o = misalign_r;

`ifdef PC_SEQ_RAS_EN
    logic            ras_push_s;
    logic            ras_pop_s;
    logic [PC_W-1:0] ras_top_s;
    logic            ras_empty_s;
    logic            ras_full_unused_s;
    logic            ras_mismatch_r;

    assign ras_push_s = update_s && (pc_src_s == PC_JUMP) && link_i;
    assign ras_pop_s  = update_s && (pc_src_s == PC_JR) && ret_i;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (pc_plus_s),
        .top       (ras_top_s),
        .empty     (ras_empty_s),
        .full      (ras_full_unused_s)
    );

    // Return-prediction check, reported one cycle after the JR retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_mismatch_r <= 1'b0;
        end else begin
            ras_mismatch_r <= ras_pop_s && (ras_empty_s || (ras_top_s != rs_val_i));
        end
    end

    assign ras_mismatch_o = ras_mismatch_r;
`else
    logic unused_s;
    assign unused_s       = ^{ret_i, 32'(RAS_DEPTH)};
    assign ras_mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed self-checking bench for pc_sequencer (PC_W=32, RESET_PC=0).
// Compile with +define+PC_SEQ_RAS_EN to include the return-address-stack steps.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic        imem_ack_i;
    logic        valid_i;
    logic        stall_i;
    logic [1:0]  pc_src_i;
    logic        link_i;
    logic        ret_i;
    logic [25:0] jaddr_i;
    logic [15:0] boff_i;
    logic [31:0] rs_val_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_o;
    logic        redirect_o;
    logic        misalign_o;
    logic        ras_mismatch_o;

    int vectors;
    int miscompares;

    pc_sequencer #(
        .PC_W      (32),
        .RESET_PC  (32'h0000_0000),
        .RAS_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_o     (imem_req_o),
        .imem_ack_i     (imem_ack_i),
        .valid_i        (valid_i),
        .stall_i        (stall_i),
        .pc_src_i       (pc_src_i),
        .link_i         (link_i),
        .ret_i          (ret_i),
        .jaddr_i        (jaddr_i),
        .boff_i         (boff_i),
        .rs_val_i       (rs_val_i),
        .pc_o           (pc_o),
        .pc_plus_o      (pc_plus_o),
        .redirect_o     (redirect_o),
        .misalign_o     (misalign_o),
        .ras_mismatch_o (ras_mismatch_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a fetch request, then acknowledge it for one cycle.
    task automatic fetch();
        int n;
        n = 0;
        while (imem_req_o !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", {31'd0, imem_req_o}, 32'd1);
        imem_ack_i = 1'b1;
        @(negedge clk);
        imem_ack_i = 1'b0;
    endtask

    // Present one instruction for a single cycle (called while in EXEC).
    task automatic issue(input logic [1:0] src, input logic lnk, input logic rt,
                         input logic [25:0] ja, input logic [15:0] bo, input logic [31:0] rs);
        pc_src_i = src;
        link_i   = lnk;
        ret_i    = rt;
        jaddr_i  = ja;
        boff_i   = bo;
        rs_val_i = rs;
        valid_i  = 1'b1;
        @(negedge clk);
        valid_i  = 1'b0;
        link_i   = 1'b0;
        ret_i    = 1'b0;
    endtask

    initial begin
        logic [31:0] ret_exp;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        imem_ack_i  = 1'b0;
        valid_i     = 1'b0;
        stall_i     = 1'b0;
        pc_src_i    = 2'b00;
        link_i      = 1'b0;
        ret_i       = 1'b0;
        jaddr_i     = 26'd0;
        boff_i      = 16'd0;
        rs_val_i    = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pc", pc_o, 32'h0000_0000);
        chk("rst_pc_plus", pc_plus_o, 32'h0000_0004);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        chk("rst_ras_mm", {31'd0, ras_mismatch_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_to_fetch_req", {31'd0, imem_req_o}, 32'd1);

        // Three sequential instructions
        fetch();
        chk("exec_req_low", {31'd0, imem_req_o}, 32'd0);
        imem_ack_i = 1'b1;              // ack outside FETCH is ignored
        @(negedge clk);
        imem_ack_i = 1'b0;
        chk("stray_ack_req", {31'd0, imem_req_o}, 32'd0);
        issue(2'b00, 1'b0, 1'b0, 26'd0, 16'd0, 32'd0);
        chk("seq1_pc", pc_o, 32'h0000_0004);
        chk("seq1_redirect", {31'd0, redirect_o}, 32'd0);
        fetch();
        issue(2'b00, 1'b0, 1'b0, 26'd0, 16'd0, 32'd0);
        chk("seq2_pc", pc_o, 32'h0000_0008);
        fetch();
        issue(2'b00, 1'b0, 1'b0, 26'd0, 16'd0, 32'd0);
        chk("seq3_pc", pc_o, 32'h0000_000C);
        chk("seq3_redirect", {31'd0, redirect_o}, 32'd0);

        // JR with ret_i set: empty RAS mismatch when enabled, otherwise ignored
`ifdef PC_SEQ_RAS_EN
        ret_exp = 32'd1;
`else
        ret_exp = 32'd0;
`endif
        fetch();
        issue(2'b11, 1'b0, 1'b1, 26'd0, 16'd0, 32'h0000_0100);
        chk("jr_pc", pc_o, 32'h0000_0100);
        chk("jr_redirect", {31'd0, redirect_o}, 32'd1);
        chk("jr_ret_ras_mm", {31'd0, ras_mismatch_o}, ret_exp);
        @(negedge clk);
        chk("jr_redirect_clear", {31'd0, redirect_o}, 32'd0);

        // Backward branch
        fetch();
        issue(2'b10, 1'b0, 1'b0, 26'd0, 16'hFFFE, 32'd0);
        chk("br_back_pc", pc_o, 32'h0000_00FC);
        chk("br_back_redirect", {31'd0, redirect_o}, 32'd1);
        @(negedge clk);
        chk("br_back_redirect_pulse", {31'd0, redirect_o}, 32'd0);

        // Branch wrapping past 2^32
        fetch();
        issue(2'b11, 1'b0, 1'b0, 26'd0, 16'd0, 32'hFFFF_FFF0);
        chk("jr_high_pc", pc_o, 32'hFFFF_FFF0);
        fetch();
        issue(2'b10, 1'b0, 1'b0, 26'd0, 16'h7FFF, 32'd0);
        chk("br_wrap_pc", pc_o, 32'h0001_FFF0);

        // Branch with zero offset still redirects
        fetch();
        issue(2'b10, 1'b0, 1'b0, 26'd0, 16'h0000, 32'd0);
        chk("br_zero_pc", pc_o, 32'h0001_FFF4);
        chk("br_zero_redirect", {31'd0, redirect_o}, 32'd1);

        // J keeps upper PC bits
        fetch();
        issue(2'b11, 1'b0, 1'b0, 26'd0, 16'd0, 32'h1000_0000);
        fetch();
        issue(2'b01, 1'b1, 1'b0, 26'h000_0040, 16'd0, 32'd0);
        chk("j_pc", pc_o, 32'h1000_0100);
        chk("j_pc_plus", pc_plus_o, 32'h1000_0104);
        chk("j_redirect", {31'd0, redirect_o}, 32'd1);

        // Stall wins over valid for 5 cycles
        fetch();
        pc_src_i = 2'b00;
        stall_i  = 1'b1;
        valid_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pc", pc_o, 32'h1000_0100);
        end
        chk("stall_req", {31'd0, imem_req_o}, 32'd0);
        stall_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        chk("unstall_pc", pc_o, 32'h1000_0104);
        chk("unstall_req", {31'd0, imem_req_o}, 32'd1);

`ifdef PC_SEQ_RAS_EN
        // Five nested JALs then five returns through a 4-deep RAS
        fetch();
        issue(2'b11, 1'b0, 1'b0, 26'd0, 16'd0, 32'h0000_1000);
        fetch();
        issue(2'b01, 1'b1, 1'b0, 26'h000_0800, 16'd0, 32'd0);
        chk("jal1_pc", pc_o, 32'h0000_2000);
        fetch();
        issue(2'b01, 1'b1, 1'b0, 26'h000_0C00, 16'd0, 32'd0);
        fetch();
        issue(2'b01, 1'b1, 1'b0, 26'h000_1000, 16'd0, 32'd0);
        fetch();
        issue(2'b01, 1'b1, 1'b0, 26'h000_1400, 16'd0, 32'd0);
        fetch();
        issue(2'b01, 1'b1, 1'b0, 26'h000_1800, 16'd0, 32'd0);
        chk("jal5_pc", pc_o, 32'h0000_6000);
        fetch();
        issue(2'b11, 1'b0, 1'b1, 26'd0, 16'd0, 32'h0000_5004);
        chk("ret1_mm", {31'd0, ras_mismatch_o}, 32'd0);
        fetch();
        issue(2'b11, 1'b0, 1'b1, 26'd0, 16'd0, 32'h0000_4004);
        chk("ret2_mm", {31'd0, ras_mismatch_o}, 32'd0);
        fetch();
        issue(2'b11, 1'b0, 1'b1, 26'd0, 16'd0, 32'h0000_3004);
        chk("ret3_mm", {31'd0, ras_mismatch_o}, 32'd0);
        fetch();
        issue(2'b11, 1'b0, 1'b1, 26'd0, 16'd0, 32'h0000_2004);
        chk("ret4_mm", {31'd0, ras_mismatch_o}, 32'd0);
        fetch();
        issue(2'b11, 1'b0, 1'b1, 26'd0, 16'd0, 32'h0000_1004);
        chk("ret5_mm", {31'd0, ras_mismatch_o}, 32'd1);
        chk("ret5_pc", pc_o, 32'h0000_1004);
        @(negedge clk);
        chk("ret5_mm_pulse", {31'd0, ras_mismatch_o}, 32'd0);
`endif

        // Reset while requesting: req drops at once, late ack ignored
        chk("pre_rst_req", {31'd0, imem_req_o}, 32'd1);
        #2;
        rst_n      = 1'b0;
        imem_ack_i = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("async_rst_pc", pc_o, 32'h0000_0000);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack_i = 1'b0;
        @(negedge clk);
        chk("late_ack_req", {31'd0, imem_req_o}, 32'd1);
        chk("late_ack_pc", pc_o, 32'h0000_0000);

        // Misaligned JR halts with PC held
        fetch();
        issue(2'b11, 1'b0, 1'b0, 26'd0, 16'd0, 32'h0000_0040);
        fetch();
        issue(2'b11, 1'b0, 1'b0, 26'd0, 16'd0, 32'h0000_2002);
        chk("halt_pc", pc_o, 32'h0000_0040);
        chk("halt_misalign", {31'd0, misalign_o}, 32'd1);
        chk("halt_req", {31'd0, imem_req_o}, 32'd0);
        imem_ack_i = 1'b1;
        issue(2'b00, 1'b0, 1'b0, 26'd0, 16'd0, 32'd0);
        imem_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("halt_hold_pc", pc_o, 32'h0000_0040);
        chk("halt_hold_misalign", {31'd0, misalign_o}, 32'd1);
        chk("halt_hold_req", {31'd0, imem_req_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
